rs: RTL and testbench
=====================

# rs

Reservation station for the out-of-order core. It buffers dispatched ALU/branch instructions and waits for their source operands by snooping the ALU and LSB common data buses. Each cycle it issues at most one ready instruction to the combinational execute unit, as registered operands. It sits between the dispatcher (upstream) and the execute unit (downstream).

## Interface
Parameters:
- RS_SIZE, 16, number of entries (power of two).
- ROB_ID_W, 4, ROB tag width. Tag 0 (`ZERO_ROB_ID`) means "operand ready"; live ROB tags are 1..2^ROB_ID_W-1.

Ports:
- clk_in  in  1  clock. One clock domain.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global ready. Low freezes all entry state.
- dispatch_en  in  1  dispatcher presents an instruction this cycle.
- dispatch_openum  in  `OPENUM_TYPE`  operation.
- dispatch_V1, dispatch_V2  in  `DATA_TYPE`  operand values, meaningful only when the matching Q is 0.
- dispatch_Q1, dispatch_Q2  in  ROB_ID_W  producer tags; 0 means ready.
- dispatch_imm  in  `DATA_TYPE`  immediate.
- dispatch_pc  in  `ADDR_TYPE`  instruction pc.
- dispatch_rob_id  in  ROB_ID_W  destination tag.
- full  out  1  no free entry. Combinational from registered state only.
- alu_cdb_valid, lsb_cdb_valid  in  1  broadcast strobes.
- alu_cdb_rob_id, lsb_cdb_rob_id  in  ROB_ID_W  broadcast tags.
- alu_cdb_result, lsb_cdb_result  in  `DATA_TYPE`  broadcast values.
- rollback_flag  in  1  misprediction flush.
- ex_openum  out  `OPENUM_TYPE`  issued operation; `OPENUM_NOP` when idle.
- ex_V1, ex_V2, ex_imm  out  `DATA_TYPE`  issued operands.
- ex_pc  out  `ADDR_TYPE`  issued pc.
- ex_rob_id  out  ROB_ID_W  issued destination tag, consumed with the execute-unit result.

## Operation
- Each entry holds: busy, openum, V1, Q1, V2, Q2, imm, pc, rob_id.
- Priority per rising edge: rst_in, then rollback_flag, then !rdy_in, then normal operation.
- Reset and rollback:
  - All busy bits cleared.
  - ex_openum set to `OPENUM_NOP`; all other ex_* outputs set to 0.
  - Dispatch and CDB inputs are ignored in that cycle.
- rdy_in low:
  - Entries are unchanged.
  - ex_openum is set to `OPENUM_NOP` so nothing is executed twice; other ex_* outputs hold.
- Issue (normal cycle):
  - Select the lowest-index entry with busy && Q1==0 && Q2==0, using start-of-cycle state.
  - Copy its fields to ex_*, clear its busy bit.
  - If no entry is ready, ex_openum is set to `OPENUM_NOP`.
- Dispatch (normal cycle):
  - When dispatch_en && !full, write into the lowest-index non-busy entry (start-of-cycle state).
  - A slot freed by issue in the same cycle is not reusable until the next cycle.
  - dispatch_en while full is dropped; no entry is modified.
- Wakeup (normal cycle):
  - For every busy entry and each operand, if Qx matches a valid CDB tag, set Vx to that bus's result and Qx to 0.
  - The same check applies to the incoming dispatch operands, so a producer broadcasting in the dispatch cycle is captured.
  - Tag 0 never matches.
  - ALU and LSB tags are never equal in one cycle; if they are, the ALU value wins.
- Entries are never issued out of the ready set by age; lowest index wins. No starvation guarantee beyond this.

## Timing
- All outputs are registered except full.
- Dispatch with both operands ready at edge N: entry becomes busy at N. The instruction is issued at N+1, so ex_* is valid after N+1.
- CDB broadcast sampled at edge N clears Q at N. The entry is issuable at N+1. There is no same-cycle CDB-to-issue bypass.
- Sustained throughput is one issue per cycle.
- full rises in the cycle after the last free slot is taken. It falls in the cycle after an issue with no dispatch.
- A rollback in the same cycle as dispatch, issue, or CDB activity: rollback wins, and all three are discarded.

## Structure
- Shared `defines.v` holds:
  - `OPENUM_*` constants and `OPENUM_TYPE`.
  - `DATA_TYPE`, `ADDR_TYPE`, `ZERO_WORD`, `ZERO_ADDR`.
  - `ROB_ID_TYPE`, `ZERO_ROB_ID`, `RS_SIZE`.
- One natural sub-module, `rs_pick`: a parameterised lowest-index priority encoder. It is instantiated twice, once for the free slot and once for the ready slot, and outputs an index plus a found flag.
- The execute unit stays a separate module fed by ex_*.

## Test plan
- Reset, then one dispatch of ADD with V1=5, V2=7, Q1=Q2=0, rob_id=3 → one cycle later ex_openum=ADD, ex_V1=5, ex_V2=7, ex_rob_id=3; following cycle ex_openum=NOP.
- Dispatch ADDI with Q1=4, then alu_cdb_valid with rob_id=4, result=0x10 → no issue until the CDB cycle+1; then ex_V1=0x10.
- Dispatch with Q2=6 while lsb_cdb broadcasts tag 6 value 0xAB in the same cycle → issued next cycle with ex_V2=0xAB.
- Fill all 16 entries with Q1=2 → full=1; a 17th dispatch is dropped; a CDB broadcast of tag 2 → 16 consecutive issues in index order, then full=0.
- Two ready entries plus rollback_flag asserted → no issue, ex_openum=NOP, full=0; entries never appear later.
- rdy_in low for 3 cycles with ready entries → ex_openum=NOP throughout; issue resumes at the first cycle with rdy_in high.

Source files
------------

// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pkg
//  Description : Shared types and constants for the reservation station:
//                operation encodings, datapath widths and zero values.
//  Revision    : 1.0  initial release
// ============================================================================
package rs_pkg;

    // Datapath widths
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int OPENUM_W = 6;

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [OPENUM_W-1:0] openum_t;

    // Default geometry of the station
    localparam int RS_SIZE_DEF  = 16;
    localparam int ROB_ID_W_DEF = 4;

    localparam data_t ZERO_WORD = '0;
    localparam addr_t ZERO_ADDR = '0;

    // Operation encodings (NOP must stay zero: it marks an idle execute slot)
    localparam openum_t OPENUM_NOP  = 6'd0;
    localparam openum_t OPENUM_ADD  = 6'd1;
    localparam openum_t OPENUM_SUB  = 6'd2;
    localparam openum_t OPENUM_AND  = 6'd3;
    localparam openum_t OPENUM_OR   = 6'd4;
    localparam openum_t OPENUM_XOR  = 6'd5;
    localparam openum_t OPENUM_SLL  = 6'd6;
    localparam openum_t OPENUM_SRL  = 6'd7;
    localparam openum_t OPENUM_SRA  = 6'd8;
    localparam openum_t OPENUM_SLT  = 6'd9;
    localparam openum_t OPENUM_SLTU = 6'd10;
    localparam openum_t OPENUM_ADDI = 6'd11;
    localparam openum_t OPENUM_BEQ  = 6'd20;
    localparam openum_t OPENUM_BNE  = 6'd21;
    localparam openum_t OPENUM_BLT  = 6'd22;
    localparam openum_t OPENUM_BGE  = 6'd23;
    localparam openum_t OPENUM_JAL  = 6'd24;
    localparam openum_t OPENUM_JALR = 6'd25;

    // Tag-independent part of an entry
    typedef struct packed {
        openum_t openum;
        data_t   imm;
        addr_t   pc;
    } rs_payload_t;

endpackage : rs_pkg
`default_nettype wire

// File: rtl/rs_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pick
//  Description : Lowest-index priority encoder. Returns the index of the
//                lowest set request bit and a flag telling whether any bit
//                was set (index is 0 when none is).
//  Revision    : 1.0  initial release
// ============================================================================
module rs_pick #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule : rs_pick
`default_nettype wire

// File: rtl/rs.sv
`default_nettype none
// ============================================================================
//  Module      : rs
//  Description : Reservation station. Buffers dispatched ALU/branch ops,
//                snoops the ALU and LSB common data buses for missing
//                operands and issues at most one ready op per cycle, lowest
//                index first, as registered operands to the execute unit.
//  Revision    : 1.0  initial release
// ============================================================================
module rs
    import rs_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int ROB_ID_W = ROB_ID_W_DEF
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,

    // Dispatcher
    input  logic                dispatch_en,
    input  openum_t             dispatch_openum,
    input  data_t               dispatch_V1,
    input  data_t               dispatch_V2,
    input  logic [ROB_ID_W-1:0] dispatch_Q1,
    input  logic [ROB_ID_W-1:0] dispatch_Q2,
    input  data_t               dispatch_imm,
    input  addr_t               dispatch_pc,
    input  logic [ROB_ID_W-1:0] dispatch_rob_id,
    output logic                full,

    // Common data buses
    input  logic                alu_cdb_valid,
    input  logic [ROB_ID_W-1:0] alu_cdb_rob_id,
    input  data_t               alu_cdb_result,
    input  logic                lsb_cdb_valid,
    input  logic [ROB_ID_W-1:0] lsb_cdb_rob_id,
    input  data_t               lsb_cdb_result,

    // Flush
    input  logic                rollback_flag,

    // Execute unit
    output openum_t             ex_openum,
    output data_t               ex_V1,
    output data_t               ex_V2,
    output data_t               ex_imm,
    output addr_t               ex_pc,
    output logic [ROB_ID_W-1:0] ex_rob_id
);

    localparam int c_idx_w = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [RS_SIZE-1:0]  r_busy;
    rs_payload_t         r_payload [RS_SIZE];
    data_t               r_v1      [RS_SIZE];
    data_t               r_v2      [RS_SIZE];
    logic [ROB_ID_W-1:0] r_q1      [RS_SIZE];
    logic [ROB_ID_W-1:0] r_q2      [RS_SIZE];
    logic [ROB_ID_W-1:0] r_rob_id  [RS_SIZE];

    // Operands after CDB wakeup, per entry and for the incoming dispatch
    data_t               w_v1 [RS_SIZE];
    data_t               w_v2 [RS_SIZE];
    logic [ROB_ID_W-1:0] w_q1 [RS_SIZE];
    logic [ROB_ID_W-1:0] w_q2 [RS_SIZE];
    data_t               w_d_v1;
    data_t               w_d_v2;
    logic [ROB_ID_W-1:0] w_d_q1;
    logic [ROB_ID_W-1:0] w_d_q2;

    logic [RS_SIZE-1:0]  w_ready;
    logic [c_idx_w-1:0]  w_ready_idx;
    logic                w_ready_found;
    logic [c_idx_w-1:0]  w_free_idx;
    logic                w_free_found;
    logic                w_normal;
    logic                w_do_dispatch;

    // A tag matches a bus only when the bus is valid and the tag is live
    function automatic logic tag_hit(
        input logic [ROB_ID_W-1:0] q,
        input logic                valid,
        input logic [ROB_ID_W-1:0] tag
    );
        return valid && (q != '0) && (q == tag);
    endfunction

    // ------------------------------------------------------------------
    // Selection: ready and free slots, both from start-of-cycle state
    // ------------------------------------------------------------------

    // Ready means busy with both producer tags already resolved
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_ready[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
        end
    end

    rs_pick #(.N(RS_SIZE), .IDX_W(c_idx_w)) u_pick_ready (
        .req   (w_ready),
        .idx   (w_ready_idx),
        .found (w_ready_found)
    );

    rs_pick #(.N(RS_SIZE), .IDX_W(c_idx_w)) u_pick_free (
        .req   (~r_busy),
        .idx   (w_free_idx),
        .found (w_free_found)
    );

    assign full          = &r_busy;
    assign w_normal      = !rst_in && !rollback_flag && rdy_in;
    assign w_do_dispatch = dispatch_en && w_free_found;

    // ------------------------------------------------------------------
    // Wakeup: ALU bus takes precedence if both buses carry the same tag
    // ------------------------------------------------------------------

    // Resolve stored operands against this cycle's broadcasts
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_v1[i] = r_v1[i];
            w_q1[i] = r_q1[i];
            w_v2[i] = r_v2[i];
            w_q2[i] = r_q2[i];
            if (tag_hit(r_q1[i], alu_cdb_valid, alu_cdb_rob_id)) begin
                w_v1[i] = alu_cdb_result;
                w_q1[i] = '0;
            end else if (tag_hit(r_q1[i], lsb_cdb_valid, lsb_cdb_rob_id)) begin
                w_v1[i] = lsb_cdb_result;
                w_q1[i] = '0;
            end
            if (tag_hit(r_q2[i], alu_cdb_valid, alu_cdb_rob_id)) begin
                w_v2[i] = alu_cdb_result;
                w_q2[i] = '0;
            end else if (tag_hit(r_q2[i], lsb_cdb_valid, lsb_cdb_rob_id)) begin
                w_v2[i] = lsb_cdb_result;
                w_q2[i] = '0;
            end
        end
    end

    // Resolve incoming dispatch operands so a same-cycle producer is not lost
    always_comb begin
        w_d_v1 = dispatch_V1;
        w_d_q1 = dispatch_Q1;
        w_d_v2 = dispatch_V2;
        w_d_q2 = dispatch_Q2;
        if (tag_hit(dispatch_Q1, alu_cdb_valid, alu_cdb_rob_id)) begin
            w_d_v1 = alu_cdb_result;
            w_d_q1 = '0;
        end else if (tag_hit(dispatch_Q1, lsb_cdb_valid, lsb_cdb_rob_id)) begin
            w_d_v1 = lsb_cdb_result;
            w_d_q1 = '0;
        end
        if (tag_hit(dispatch_Q2, alu_cdb_valid, alu_cdb_rob_id)) begin
            w_d_v2 = alu_cdb_result;
            w_d_q2 = '0;
        end else if (tag_hit(dispatch_Q2, lsb_cdb_valid, lsb_cdb_rob_id)) begin
            w_d_v2 = lsb_cdb_result;
            w_d_q2 = '0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Busy bits and the issue register; flush and freeze handling live here
    always_ff @(posedge clk_in) begin
        if (rst_in || rollback_flag) begin
            r_busy    <= '0;
            ex_openum <= OPENUM_NOP;
            ex_V1     <= ZERO_WORD;
            ex_V2     <= ZERO_WORD;
            ex_imm    <= ZERO_WORD;
            ex_pc     <= ZERO_ADDR;
            ex_rob_id <= '0;
        end else if (!rdy_in) begin
            // Hold everything but never present the same op twice
            ex_openum <= OPENUM_NOP;
        end else begin
            if (w_ready_found) begin
                ex_openum             <= r_payload[w_ready_idx].openum;
                ex_V1                 <= r_v1[w_ready_idx];
                ex_V2                 <= r_v2[w_ready_idx];
                ex_imm                <= r_payload[w_ready_idx].imm;
                ex_pc                 <= r_payload[w_ready_idx].pc;
                ex_rob_id             <= r_rob_id[w_ready_idx];
                r_busy[w_ready_idx]   <= 1'b0;
            end else begin
                ex_openum <= OPENUM_NOP;
            end
            // Free slot is non-busy, issued slot is busy: never the same index
            if (w_do_dispatch) begin
                r_busy[w_free_idx] <= 1'b1;
            end
        end
    end

    // Entry contents: wakeup on busy entries, fill on dispatch
    always_ff @(posedge clk_in) begin
        if (w_normal) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    r_v1[i] <= w_v1[i];
                    r_q1[i] <= w_q1[i];
                    r_v2[i] <= w_v2[i];
                    r_q2[i] <= w_q2[i];
                end
            end
            if (w_do_dispatch) begin
                r_payload[w_free_idx].openum <= dispatch_openum;
                r_payload[w_free_idx].imm    <= dispatch_imm;
                r_payload[w_free_idx].pc     <= dispatch_pc;
                r_rob_id[w_free_idx]         <= dispatch_rob_id;
                r_v1[w_free_idx]             <= w_d_v1;
                r_q1[w_free_idx]             <= w_d_q1;
                r_v2[w_free_idx]             <= w_d_v2;
                r_q2[w_free_idx]             <= w_d_q2;
            end
        end
    end

endmodule : rs
`default_nettype wire

// File: tb/tb_rs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs
//  Description : Self-checking bench for rs. Stimulus pushes the expected
//                issued instruction into a scoreboard queue; a monitor pops
//                and compares whenever ex_openum is not NOP.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs;
    import rs_pkg::*;

    localparam int ROB_ID_W = 4;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b1;
    logic                rdy_in = 1'b1;
    logic                dispatch_en = 1'b0;
    openum_t             dispatch_openum = OPENUM_NOP;
    data_t               dispatch_V1 = '0;
    data_t               dispatch_V2 = '0;
    logic [ROB_ID_W-1:0] dispatch_Q1 = '0;
    logic [ROB_ID_W-1:0] dispatch_Q2 = '0;
    data_t               dispatch_imm = '0;
    addr_t               dispatch_pc = '0;
    logic [ROB_ID_W-1:0] dispatch_rob_id = '0;
    logic                full;
    logic                alu_cdb_valid = 1'b0;
    logic [ROB_ID_W-1:0] alu_cdb_rob_id = '0;
    data_t               alu_cdb_result = '0;
    logic                lsb_cdb_valid = 1'b0;
    logic [ROB_ID_W-1:0] lsb_cdb_rob_id = '0;
    data_t               lsb_cdb_result = '0;
    logic                rollback_flag = 1'b0;
    openum_t             ex_openum;
    data_t               ex_V1;
    data_t               ex_V2;
    data_t               ex_imm;
    addr_t               ex_pc;
    logic [ROB_ID_W-1:0] ex_rob_id;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        openum_t             op;
        data_t               v1;
        data_t               v2;
        data_t               imm;
        addr_t               pc;
        logic [ROB_ID_W-1:0] rob;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    rs #(.RS_SIZE(16), .ROB_ID_W(ROB_ID_W)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .dispatch_en     (dispatch_en),
        .dispatch_openum (dispatch_openum),
        .dispatch_V1     (dispatch_V1),
        .dispatch_V2     (dispatch_V2),
        .dispatch_Q1     (dispatch_Q1),
        .dispatch_Q2     (dispatch_Q2),
        .dispatch_imm    (dispatch_imm),
        .dispatch_pc     (dispatch_pc),
        .dispatch_rob_id (dispatch_rob_id),
        .full            (full),
        .alu_cdb_valid   (alu_cdb_valid),
        .alu_cdb_rob_id  (alu_cdb_rob_id),
        .alu_cdb_result  (alu_cdb_result),
        .lsb_cdb_valid   (lsb_cdb_valid),
        .lsb_cdb_rob_id  (lsb_cdb_rob_id),
        .lsb_cdb_result  (lsb_cdb_result),
        .rollback_flag   (rollback_flag),
        .ex_openum       (ex_openum),
        .ex_V1           (ex_V1),
        .ex_V2           (ex_V2),
        .ex_imm          (ex_imm),
        .ex_pc           (ex_pc),
        .ex_rob_id       (ex_rob_id)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_dispatch(input openum_t op, input data_t v1, input logic [ROB_ID_W-1:0] q1,
                                input data_t v2, input logic [ROB_ID_W-1:0] q2, input data_t imm,
                                input addr_t pc, input logic [ROB_ID_W-1:0] rob);
        dispatch_en     = 1'b1;
        dispatch_openum = op;
        dispatch_V1     = v1;
        dispatch_Q1     = q1;
        dispatch_V2     = v2;
        dispatch_Q2     = q2;
        dispatch_imm    = imm;
        dispatch_pc     = pc;
        dispatch_rob_id = rob;
    endtask

    task automatic expect_issue(input openum_t op, input data_t v1, input data_t v2, input data_t imm,
                                input addr_t pc, input logic [ROB_ID_W-1:0] rob);
        exp_t e;
        e.op = op; e.v1 = v1; e.v2 = v2; e.imm = imm; e.pc = pc; e.rob = rob;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        dispatch_en   = 1'b0;
        alu_cdb_valid = 1'b0;
        lsb_cdb_valid = 1'b0;
        rollback_flag = 1'b0;
    endtask

    // Monitor: every non-NOP issue must match the oldest expected entry
    always @(negedge clk_in) begin
        if (!rst_in && ex_openum !== OPENUM_NOP) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_issue actual op=%0d pc=0x%0h rob=%0d required no issue",
                         ex_openum, ex_pc, ex_rob_id);
            end else begin
                mon_e = sb.pop_front();
                if (ex_openum !== mon_e.op || ex_V1 !== mon_e.v1 || ex_V2 !== mon_e.v2 ||
                    ex_imm !== mon_e.imm || ex_pc !== mon_e.pc || ex_rob_id !== mon_e.rob) begin
                    failures++;
                    $display("FAIL issue_fields actual op=%0d V1=0x%0h V2=0x%0h imm=0x%0h pc=0x%0h rob=%0d required op=%0d V1=0x%0h V2=0x%0h imm=0x%0h pc=0x%0h rob=%0d",
                             ex_openum, ex_V1, ex_V2, ex_imm, ex_pc, ex_rob_id,
                             mon_e.op, mon_e.v1, mon_e.v2, mon_e.imm, mon_e.pc, mon_e.rob);
                end
            end
        end
    end

    initial begin
        // ---------------- Reset ----------------
        rst_in = 1'b1;
        repeat (2) tick();
        rst_in = 1'b0;
        check("reset_ex_openum", 32'(ex_openum), 32'(OPENUM_NOP));
        check("reset_ex_V1", ex_V1, 32'h0);
        check("reset_ex_rob_id", 32'(ex_rob_id), 32'h0);
        check("reset_full", 32'(full), 32'h0);

        // ---------------- Ready dispatch, issue next cycle ----------------
        set_dispatch(OPENUM_ADD, 32'd5, 4'd0, 32'd7, 4'd0, 32'h0, 32'h100, 4'd3);
        expect_issue(OPENUM_ADD, 32'd5, 32'd7, 32'h0, 32'h100, 4'd3);
        tick();
        idle_inputs();
        check("add_not_yet", 32'(ex_openum), 32'(OPENUM_NOP));
        tick();
        check("add_op", 32'(ex_openum), 32'(OPENUM_ADD));
        check("add_V1", ex_V1, 32'd5);
        check("add_V2", ex_V2, 32'd7);
        check("add_rob", 32'(ex_rob_id), 32'd3);
        tick();
        check("add_then_nop", 32'(ex_openum), 32'(OPENUM_NOP));

        // ---------------- ALU CDB wakeup ----------------
        set_dispatch(OPENUM_ADDI, 32'h0, 4'd4, 32'h0, 4'd0, 32'h1, 32'h200, 4'd5);
        tick();
        idle_inputs();
        repeat (2) begin
            tick();
            check("addi_waiting", 32'(ex_openum), 32'(OPENUM_NOP));
        end
        alu_cdb_valid  = 1'b1;
        alu_cdb_rob_id = 4'd4;
        alu_cdb_result = 32'h10;
        expect_issue(OPENUM_ADDI, 32'h10, 32'h0, 32'h1, 32'h200, 4'd5);
        tick();
        idle_inputs();
        check("addi_no_bypass", 32'(ex_openum), 32'(OPENUM_NOP));
        tick();
        check("addi_op", 32'(ex_openum), 32'(OPENUM_ADDI));
        check("addi_V1", ex_V1, 32'h10);
        tick();

        // ---------------- LSB CDB captured in the dispatch cycle ----------------
        set_dispatch(OPENUM_SUB, 32'h1, 4'd0, 32'h0, 4'd6, 32'h0, 32'h300, 4'd7);
        lsb_cdb_valid  = 1'b1;
        lsb_cdb_rob_id = 4'd6;
        lsb_cdb_result = 32'hAB;
        expect_issue(OPENUM_SUB, 32'h1, 32'hAB, 32'h0, 32'h300, 4'd7);
        tick();
        idle_inputs();
        tick();
        check("sub_op", 32'(ex_openum), 32'(OPENUM_SUB));
        check("sub_V2", ex_V2, 32'hAB);
        tick();

        // ---------------- Fill, drop overflow, drain in index order ----------------
        for (int i = 0; i < 16; i++) begin
            set_dispatch(OPENUM_ADD, 32'h0, 4'd2, 32'(i), 4'd0, 32'h0, 32'(i * 4), 4'((i % 15) + 1));
            tick();
            if (i == 14) check("full_before_last", 32'(full), 32'h0);
        end
        idle_inputs();
        check("full_after_16", 32'(full), 32'h1);
        set_dispatch(OPENUM_SUB, 32'h1, 4'd0, 32'h1, 4'd0, 32'h0, 32'hDEAD, 4'd9);
        tick();
        idle_inputs();
        check("full_after_drop", 32'(full), 32'h1);
        alu_cdb_valid  = 1'b1;
        alu_cdb_rob_id = 4'd2;
        alu_cdb_result = 32'h22;
        for (int i = 0; i < 16; i++) begin
            expect_issue(OPENUM_ADD, 32'h22, 32'(i), 32'h0, 32'(i * 4), 4'((i % 15) + 1));
        end
        tick();
        idle_inputs();
        check("full_at_broadcast", 32'(full), 32'h1);
        check("drain_not_yet", 32'(ex_openum), 32'(OPENUM_NOP));
        for (int i = 0; i < 16; i++) begin
            tick();
            check("drain_pc", ex_pc, 32'(i * 4));
        end
        check("full_after_drain", 32'(full), 32'h0);
        tick();
        check("drain_then_nop", 32'(ex_openum), 32'(OPENUM_NOP));

        // ---------------- Rollback discards ready entries ----------------
        set_dispatch(OPENUM_XOR, 32'h0, 4'd9, 32'h3, 4'd0, 32'h0, 32'h500, 4'd10);
        tick();
        set_dispatch(OPENUM_OR, 32'h0, 4'd9, 32'h4, 4'd0, 32'h0, 32'h504, 4'd11);
        tick();
        idle_inputs();
        alu_cdb_valid  = 1'b1;
        alu_cdb_rob_id = 4'd9;
        alu_cdb_result = 32'h99;
        tick();
        idle_inputs();
        rollback_flag  = 1'b1;
        set_dispatch(OPENUM_AND, 32'h5, 4'd0, 32'h6, 4'd0, 32'h0, 32'h600, 4'd12);
        lsb_cdb_valid  = 1'b1;
        lsb_cdb_rob_id = 4'd13;
        lsb_cdb_result = 32'h55;
        tick();
        idle_inputs();
        check("rollback_nop", 32'(ex_openum), 32'(OPENUM_NOP));
        check("rollback_full", 32'(full), 32'h0);
        check("rollback_rob_zero", 32'(ex_rob_id), 32'h0);
        repeat (3) begin
            tick();
            check("rollback_stays_empty", 32'(ex_openum), 32'(OPENUM_NOP));
        end

        // ---------------- rdy_in low freezes issue ----------------
        set_dispatch(OPENUM_SLT, 32'h0, 4'd11, 32'h8, 4'd0, 32'h0, 32'h700, 4'd1);
        tick();
        set_dispatch(OPENUM_BEQ, 32'h0, 4'd11, 32'h9, 4'd0, 32'h4, 32'h704, 4'd2);
        tick();
        idle_inputs();
        lsb_cdb_valid  = 1'b1;
        lsb_cdb_rob_id = 4'd11;
        lsb_cdb_result = 32'h77;
        tick();
        idle_inputs();
        rdy_in = 1'b0;
        set_dispatch(OPENUM_AND, 32'h1, 4'd0, 32'h2, 4'd0, 32'h0, 32'h800, 4'd3);
        repeat (3) begin
            tick();
            check("frozen_nop", 32'(ex_openum), 32'(OPENUM_NOP));
        end
        idle_inputs();
        rdy_in = 1'b1;
        expect_issue(OPENUM_SLT, 32'h77, 32'h8, 32'h0, 32'h700, 4'd1);
        expect_issue(OPENUM_BEQ, 32'h77, 32'h9, 32'h4, 32'h704, 4'd2);
        tick();
        check("resume_first", ex_pc, 32'h700);
        tick();
        check("resume_second", ex_pc, 32'h704);
        tick();
        check("resume_then_nop", 32'(ex_openum), 32'(OPENUM_NOP));

        // ---------------- Wrap-up ----------------
        repeat (3) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rs
`default_nettype wire
